// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the C64 phi2 bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        OWN_VIC = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_CPU,
        ST_WAIT,
        ST_VIC,
        ST_DMA
    } state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the arbiter and the bus multiplexer.
// steal_cnt exists only when BUS_ARB_STEAL_COUNT_EN is defined.
interface bus_arbiter_if;
    import bus_arb_pkg::*;

    logic   vic_req;
    logic   dma_req;
    logic   phi2;
    logic   cycle_end;
    logic   ba;
    logic   aec;
    logic   rdy;
    owner_e owner;
    logic   dma_ack;
`ifdef BUS_ARB_STEAL_COUNT_EN
    logic [15:0] steal_cnt;
`endif

    modport slave (
        input  vic_req,
        input  dma_req,
        output phi2,
        output cycle_end,
        output ba,
        output aec,
        output rdy,
        output owner,
`ifdef BUS_ARB_STEAL_COUNT_EN
        output steal_cnt,
`endif
        output dma_ack
    );

    modport master (
        output vic_req,
        output dma_req,
        input  phi2,
        input  cycle_end,
        input  ba,
        input  aec,
        input  rdy,
        input  owner,
`ifdef BUS_ARB_STEAL_COUNT_EN
        input  steal_cnt,
`endif
        input  dma_ack
    );

endinterface

// File: rtl/bus_arbiter_phase_gen.sv
// Dot counter producing registered phi2 and end-of-cycle strobe.
module phase_gen #(
    parameter int DOTS_PER_CYCLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic phi2,
    output logic cycle_end
);

    localparam int DW = $clog2(DOTS_PER_CYCLE);
    localparam logic [DW-1:0] LAST = DW'(DOTS_PER_CYCLE - 1);
    localparam logic [DW-1:0] HALF = DW'(DOTS_PER_CYCLE / 2);

    logic [DW-1:0] dc_q, dc_d;
    logic          phi2_q, phi2_d;
    logic          ce_q, ce_d;

    // Phase flags are precomputed from the next count so they stay registered.
    always_comb begin
        dc_d   = (dc_q == LAST) ? '0 : dc_q + 1'b1;
        phi2_d = (dc_d >= HALF);
        ce_d   = (dc_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q   <= '0;
            phi2_q <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            dc_q   <= dc_d;
            phi2_q <= phi2_d;
            ce_q   <= ce_d;
        end
    end

    assign phi2      = phi2_q;
    assign cycle_end = ce_q;

endmodule

// File: rtl/bus_arbiter.sv
// C64 phi2 arbiter: CPU / VIC-II / expansion DMA with BA-to-AEC delay.
// Define BUS_ARB_STEAL_COUNT_EN to add the VIC stolen-cycle counter.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DOTS_PER_CYCLE = 8,
    parameter int BA_DELAY       = 3
) (
    input  logic      dot_clk,
    input  logic      res_n,
    bus_arbiter_if.slave bus
);

    localparam logic [2:0] WC_LOAD = 3'(BA_DELAY);

    logic   phi2;
    logic   cycle_end;

    state_e state_q, state_d;
    owner_e tgt_q, tgt_d;
    owner_e wown_q, wown_d;
    logic [2:0] wc_q, wc_d;
    logic   ba_q, ba_d;
    logic   ack_q, ack_d;
    owner_e tgt_n;
    logic   drop;

    phase_gen #(
        .DOTS_PER_CYCLE(DOTS_PER_CYCLE)
    ) u_phase (
        .clk      (dot_clk),
        .rst_n    (res_n),
        .phi2     (phi2),
        .cycle_end(cycle_end)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        wown_d  = wown_q;
        wc_d    = wc_q;
        tgt_n   = tgt_q;
        drop    = 1'b0;
        if (cycle_end) begin
            unique case (state_q)
                ST_CPU: begin
                    if (bus.vic_req || bus.dma_req) begin
                        state_d = ST_WAIT;
                        tgt_d   = bus.vic_req ? OWN_VIC : OWN_DMA;
                        wown_d  = OWN_CPU;
                        wc_d    = WC_LOAD;
                    end
                end
                ST_WAIT: begin
                    // Retargeting keeps the running count; only a full drop aborts.
                    if (tgt_q == OWN_DMA) begin
                        if (bus.vic_req)
                            tgt_n = OWN_VIC;
                        else if (!bus.dma_req)
                            drop = 1'b1;
                    end else if (!bus.vic_req) begin
                        if (bus.dma_req)
                            tgt_n = OWN_DMA;
                        else
                            drop = 1'b1;
                    end
                    tgt_d = tgt_n;
                    if (drop)
                        state_d = ST_CPU;
                    else if (wc_q == 3'd1)
                        state_d = (tgt_n == OWN_VIC) ? ST_VIC : ST_DMA;
                    else
                        wc_d = wc_q - 3'd1;
                end
                ST_VIC: begin
                    if (!bus.vic_req) begin
                        if (bus.dma_req) begin
                            state_d = ST_WAIT;
                            tgt_d   = OWN_DMA;
                            wown_d  = OWN_CPU;
                            wc_d    = WC_LOAD;
                        end else begin
                            state_d = ST_CPU;
                        end
                    end
                end
                ST_DMA: begin
                    if (bus.vic_req) begin
                        state_d = ST_WAIT;
                        tgt_d   = OWN_VIC;
                        wown_d  = bus.dma_req ? OWN_DMA : OWN_CPU;
                        wc_d    = WC_LOAD;
                    end else if (!bus.dma_req) begin
                        state_d = ST_CPU;
                    end
                end
                default: state_d = ST_CPU;
            endcase
        end
        ba_d  = (state_d == ST_CPU);
        ack_d = (state_d == ST_DMA);
    end

    always_ff @(posedge dot_clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_CPU;
            tgt_q   <= OWN_VIC;
            wown_q  <= OWN_CPU;
            wc_q    <= 3'd0;
            ba_q    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            wown_q  <= wown_d;
            wc_q    <= wc_d;
            ba_q    <= ba_d;
            ack_q   <= ack_d;
        end
    end

`ifdef BUS_ARB_STEAL_COUNT_EN
    logic [15:0] steal_q, steal_d;

    always_comb begin
        steal_d = steal_q;
        if (cycle_end && state_q == ST_VIC)
            steal_d = steal_q + 16'd1;
    end

    always_ff @(posedge dot_clk or negedge res_n) begin
        if (!res_n)
            steal_q <= 16'd0;
        else
            steal_q <= steal_d;
    end

    assign bus.steal_cnt = steal_q;
`endif

    owner_e own_p2;

    // During WAIT the pre-wait master still drives phi2.
    always_comb begin
        own_p2 = OWN_CPU;
        unique case (1'b1)
            state_q == ST_CPU:  own_p2 = OWN_CPU;
            state_q == ST_WAIT: own_p2 = wown_q;
            state_q == ST_VIC:  own_p2 = OWN_VIC;
            state_q == ST_DMA:  own_p2 = OWN_DMA;
            default:            own_p2 = OWN_CPU;
        endcase
    end

    assign bus.phi2      = phi2;
    assign bus.cycle_end = cycle_end;
    assign bus.ba        = ba_q;
    assign bus.rdy       = ba_q;
    assign bus.dma_ack   = ack_q;
    assign bus.aec       = phi2 & (state_q != ST_VIC);
    assign bus.owner     = phi2 ? own_p2 : OWN_VIC;

endmodule

// File: tb/tb_bus_arbiter.sv
// Cycle-table bench for bus_arbiter with expectation scoreboard.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic dot_clk = 1'b0;
    logic res_n   = 1'b0;

    always #5 dot_clk = ~dot_clk;

    bus_arbiter_if bus();

    bus_arbiter #(
        .DOTS_PER_CYCLE(8),
        .BA_DELAY      (3)
    ) dut (
        .dot_clk(dot_clk),
        .res_n  (res_n),
        .bus    (bus)
    );

    typedef struct {
        logic       vic;
        logic       dma;
        logic       glitch;
        logic       ba;
        logic       aec2;
        logic [1:0] own;
        logic       ack;
    } rec_t;

    rec_t vec[$];
    rec_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   exp_steal = 0;

    function automatic void add(int n, logic vic, logic dma, logic gl,
                                logic ba, logic aec2, logic [1:0] own,
                                logic ack);
        rec_t r;
        r = '{vic, dma, gl, ba, aec2, own, ack};
        for (int i = 0; i < n; i++) vec.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_phi2"}, 16'(bus.phi2), 16'd0);
        chk({tag, "_ce"}, 16'(bus.cycle_end), 16'd0);
        chk({tag, "_ba"}, 16'(bus.ba), 16'd1);
        chk({tag, "_aec"}, 16'(bus.aec), 16'd0);
        chk({tag, "_rdy"}, 16'(bus.rdy), 16'd1);
        chk({tag, "_owner"}, 16'(bus.owner), 16'(OWN_VIC));
        chk({tag, "_ack"}, 16'(bus.dma_ack), 16'd0);
`ifdef BUS_ARB_STEAL_COUNT_EN
        chk({tag, "_steal"}, bus.steal_cnt, 16'd0);
`endif
    endtask

    // Entered and left at dc=0, away from the clock edge.
    task automatic run_cycle(input rec_t r);
        rec_t e;
        string p;
        p = $sformatf("c%0d", cyc);
        bus.vic_req = r.vic | r.glitch;
        bus.dma_req = r.dma;
        sb.push_back(r);
        e = sb.pop_front();
        chk({p, "_p1_phi2"}, 16'(bus.phi2), 16'd0);
        chk({p, "_p1_ce"}, 16'(bus.cycle_end), 16'd0);
        chk({p, "_p1_aec"}, 16'(bus.aec), 16'd0);
        chk({p, "_p1_owner"}, 16'(bus.owner), 16'(OWN_VIC));
        chk({p, "_ba"}, 16'(bus.ba), 16'(e.ba));
        chk({p, "_rdy"}, 16'(bus.rdy), 16'(e.ba));
        chk({p, "_ack"}, 16'(bus.dma_ack), 16'(e.ack));
`ifdef BUS_ARB_STEAL_COUNT_EN
        chk({p, "_steal"}, bus.steal_cnt, 16'(exp_steal));
`endif
        repeat (5) @(posedge dot_clk);
        #1;
        bus.vic_req = r.vic;
        chk({p, "_p2_phi2"}, 16'(bus.phi2), 16'd1);
        chk({p, "_p2_aec"}, 16'(bus.aec), 16'(e.aec2));
        chk({p, "_p2_owner"}, 16'(bus.owner), 16'(e.own));
        chk({p, "_p2_ba"}, 16'(bus.ba), 16'(e.ba));
        repeat (2) @(posedge dot_clk);
        #1;
        chk({p, "_ce"}, 16'(bus.cycle_end), 16'd1);
        @(posedge dot_clk);
        #1;
        if (e.own == OWN_VIC) exp_steal++;
        cyc++;
    endtask

    initial begin
        rec_t idle;
        idle = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, OWN_CPU, 1'b0};
        bus.vic_req = 1'b0;
        bus.dma_req = 1'b0;
        repeat (3) @(posedge dot_clk);
        #1;
        reset_chk("rst");

        //  n  vic dma gl  ba aec2 owner    ack
        add(10, 0, 0, 0, 1, 1, OWN_CPU, 0);
        add(1,  1, 0, 0, 1, 1, OWN_CPU, 0);
        add(3,  1, 0, 0, 0, 1, OWN_CPU, 0);
        add(36, 1, 0, 0, 0, 0, OWN_VIC, 0);
        add(1,  0, 0, 0, 0, 0, OWN_VIC, 0);
        add(3,  0, 0, 0, 1, 1, OWN_CPU, 0);
        add(1,  1, 1, 0, 1, 1, OWN_CPU, 0);
        add(3,  1, 1, 0, 0, 1, OWN_CPU, 0);
        add(3,  1, 1, 0, 0, 0, OWN_VIC, 0);
        add(1,  0, 1, 0, 0, 0, OWN_VIC, 0);
        add(3,  0, 1, 0, 0, 1, OWN_CPU, 0);
        add(2,  0, 1, 0, 0, 1, OWN_DMA, 1);
        add(1,  1, 1, 0, 0, 1, OWN_DMA, 1);
        add(3,  1, 1, 0, 0, 1, OWN_DMA, 0);
        add(1,  0, 0, 0, 0, 0, OWN_VIC, 0);
        add(1,  0, 0, 0, 1, 1, OWN_CPU, 0);
        add(1,  1, 0, 0, 1, 1, OWN_CPU, 0);
        add(1,  0, 0, 0, 0, 1, OWN_CPU, 0);
        add(2,  0, 0, 0, 1, 1, OWN_CPU, 0);
        add(2,  0, 0, 1, 1, 1, OWN_CPU, 0);
        add(1,  0, 1, 0, 1, 1, OWN_CPU, 0);
        add(1,  0, 0, 0, 0, 1, OWN_CPU, 0);
        add(1,  0, 0, 0, 1, 1, OWN_CPU, 0);
        add(1,  0, 1, 0, 1, 1, OWN_CPU, 0);
        add(1,  0, 1, 0, 0, 1, OWN_CPU, 0);
        add(1,  1, 1, 0, 0, 1, OWN_CPU, 0);
        add(1,  1, 0, 0, 0, 1, OWN_CPU, 0);
        add(1,  0, 0, 0, 0, 0, OWN_VIC, 0);
        add(1,  1, 0, 0, 1, 1, OWN_CPU, 0);
        add(3,  0, 1, 0, 0, 1, OWN_CPU, 0);
        add(1,  0, 0, 0, 0, 1, OWN_DMA, 1);
        add(1,  0, 0, 0, 1, 1, OWN_CPU, 0);
        add(1,  1, 0, 0, 1, 1, OWN_CPU, 0);
        add(3,  1, 0, 0, 0, 1, OWN_CPU, 0);

        @(negedge dot_clk);
        res_n = 1'b1;
        foreach (vec[i]) run_cycle(vec[i]);

        // Mid-cycle reset while the VIC owns the bus.
        bus.vic_req = 1'b1;
        repeat (5) @(posedge dot_clk);
        #1;
        chk("vic_dc5_aec", 16'(bus.aec), 16'd0);
        chk("vic_dc5_owner", 16'(bus.owner), 16'(OWN_VIC));
        chk("vic_dc5_ba", 16'(bus.ba), 16'd0);
        res_n = 1'b0;
        #1;
        reset_chk("midrst");
        bus.vic_req = 1'b0;
        @(negedge dot_clk);
        res_n     = 1'b1;
        exp_steal = 0;
        cyc       = 1000;
        for (int i = 0; i < 3; i++) run_cycle(idle);

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
